// File: rtl/car_mode_arbiter.sv
// car_mode_arbiter: fault > key > remote arbitration of the drive mode.
// Every mode change passes through a motor-off dwell; remote mode has a watchdog.
module car_mode_arbiter #(
  parameter int DWELL_CYC   = 25_000_000,
  parameter int TIMEOUT_CYC = 100_000_000,
  parameter int CNT_W       = 27
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [3:0] key_press,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_mode,
  output logic       cmd_ready,
  input  logic       fault,
  output logic [1:0] sel_type,
  output logic       motor_en,
  output logic       mode_chg,
  output logic       rmt_timeout
);
  typedef enum logic [1:0] {IDLE, DWELL, RUN, FAULT} state_t;
  localparam logic [CNT_W-1:0] DW_LIM = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC - 1);
  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d, pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             motor_q, chg_q, tmo_q, tmo_d;
  logic             key_v, cmd_acc, req_v;
  logic [1:0]       key_m, req_m;
  assign key_v   = |key_press;
  assign key_m   = key_press[0] ? 2'd0 : key_press[1] ? 2'd1 : key_press[2] ? 2'd2 : 2'd3;
  assign cmd_acc = cmd_valid && cmd_ready;
  assign req_v   = key_v || cmd_acc;
  assign req_m   = key_v ? key_m : cmd_mode;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      pend_q  <= 2'd0;
      cnt_q   <= '0;
      motor_q <= 1'b0;
      chg_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      motor_q <= state_d == RUN;
      chg_q   <= sel_d != sel_q;
      tmo_q   <= tmo_d;
    end
  end
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    if (fault) begin
      state_d = FAULT;
      sel_d   = 2'd0;
      pend_d  = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (req_v && req_m != 2'd0) begin
          state_d = DWELL;
          pend_d  = req_m;
          cnt_d   = '0;
        end
        DWELL: if (key_v && key_m == 2'd0) begin
          state_d = IDLE;
          sel_d   = 2'd0;
          pend_d  = 2'd0;
          cnt_d   = '0;
        end else if (key_v) begin
          pend_d = key_m;
          cnt_d  = '0;
        end else if (cnt_q == DW_LIM) begin
          state_d = RUN;
          sel_d   = pend_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        RUN: if (req_v && req_m != sel_q) begin
          state_d = req_m == 2'd0 ? IDLE : DWELL;
          sel_d   = req_m == 2'd0 ? 2'd0 : sel_q;
          pend_d  = req_m;
          cnt_d   = '0;
        end else if (sel_q == 2'd3) begin
          // remote watchdog: a same-mode accepted cmd still feeds it
          if (cmd_acc) cnt_d = '0;
          else if (cnt_q >= TO_LIM) begin
            state_d = IDLE;
            sel_d   = 2'd0;
            cnt_d   = '0;
            tmo_d   = 1'b1;
          end else cnt_d = cnt_q + CNT_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_comb begin
    cmd_ready   = (state_q == IDLE || state_q == RUN) && !key_v && !fault;
    sel_type    = sel_q;
    motor_en    = motor_q;
    mode_chg    = chg_q;
    rmt_timeout = tmo_q;
  end
endmodule

// File: tb/tb_car_mode_arbiter.sv
// tb_car_mode_arbiter: table vectors, directed corner sequences and random
// stimulus, all checked against a countdown-style behavioural model.
module tb_car_mode_arbiter;
  localparam int DW = 4;
  localparam int TO = 16;
  logic       sys_clk = 1'b0;
  logic       sys_rst, cmd_valid, fault, cmd_ready, motor_en, mode_chg, rmt_timeout;
  logic [3:0] key_press;
  logic [1:0] cmd_mode, sel_type;
  always #5 sys_clk = ~sys_clk;
  car_mode_arbiter #(.DWELL_CYC(DW), .TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .key_press(key_press), .cmd_valid(cmd_valid),
    .cmd_mode(cmd_mode), .cmd_ready(cmd_ready), .fault(fault), .sel_type(sel_type),
    .motor_en(motor_en), .mode_chg(mode_chg), .rmt_timeout(rmt_timeout));
  int pass_n = 0, tot_n = 0;
  int m_sel, m_motor, m_pend, m_left, m_fault, m_quiet, m_chg, m_tmo;
  int rdy_seen, tmo_hits;
  typedef struct {
    int n; logic [3:0] k; logic cv; logic [1:0] cm; logic f; logic r;
    int sel; int mot; int chg; int rdy;
  } vec_t;
  vec_t tv[7];
  task automatic chk(string nm, int act, int exp);
    tot_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
  endtask
  function automatic int low(logic [3:0] k);
    for (int i = 0; i < 4; i++) if (k[i]) return i;
    return -1;
  endfunction
  task automatic model_reset();
    m_sel = 0; m_motor = 0; m_pend = -1; m_left = 0;
    m_fault = 0; m_quiet = 0; m_chg = 0; m_tmo = 0;
  endtask
  // m_pend >= 0 means "dwelling toward m_pend", m_left cycles still to go
  task automatic model_step(logic [3:0] k, logic acc, logic [1:0] cm, logic f);
    int old, req;
    old = m_sel;
    m_tmo = 0;
    req = (k != 0) ? low(k) : acc ? int'(cm) : -1;
    if (f) begin
      m_fault = 1; m_sel = 0; m_motor = 0; m_pend = -1;
    end else if (m_fault != 0) begin
      m_fault = 0;
    end else if (m_pend >= 0) begin
      if (k != 0) begin
        if (req == 0) begin m_pend = -1; m_sel = 0; end
        else begin m_pend = req; m_left = DW; end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_sel = m_pend; m_pend = -1; m_motor = 1; m_quiet = 0;
        end
      end
    end else if (req >= 0 && req != m_sel) begin
      if (req == 0) begin m_sel = 0; m_motor = 0; end
      else begin m_pend = req; m_left = DW; m_motor = 0; end
    end else if (m_sel == 3) begin
      m_quiet = acc ? 0 : m_quiet + 1;
      if (m_quiet == TO) begin m_sel = 0; m_motor = 0; m_tmo = 1; end
    end
    m_chg = int'(m_sel != old);
  endtask
  task automatic step(logic [3:0] k, logic cv, logic [1:0] cm, logic f, logic r);
    logic er;
    key_press = k; cmd_valid = cv; cmd_mode = cm; fault = f; sys_rst = r;
    #2;
    er = m_fault == 0 && m_pend < 0 && k == 0 && !f;
    rdy_seen = int'(cmd_ready);
    if (!r) chk("cmd_ready", int'(cmd_ready), int'(er));
    if (r) model_reset();
    else model_step(k, cv && er, cm, f);
    @(posedge sys_clk);
    #1;
    chk("sel_type", int'(sel_type), m_sel);
    chk("motor_en", int'(motor_en), m_motor);
    chk("mode_chg", int'(mode_chg), m_chg);
    chk("rmt_timeout", int'(rmt_timeout), m_tmo);
    tmo_hits += int'(rmt_timeout);
  endtask
  initial begin
    int fh;
    model_reset();
    tmo_hits = 0;
    tv[0] = '{1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1, 0, 0, 0, -1};
    tv[1] = '{9, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 0, 0, 1};
    tv[2] = '{1, 4'h2, 1'b0, 2'd0, 1'b0, 1'b0, 0, 0, 0, 0};
    tv[3] = '{3, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 0, 0, 0};
    tv[4] = '{1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1, 1, 1, 0};
    tv[5] = '{1, 4'h2, 1'b0, 2'd0, 1'b0, 1'b0, 1, 1, 0, 0};
    tv[6] = '{2, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1, 1, 0, 1};
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < tv[i].n; j++) begin
        step(tv[i].k, tv[i].cv, tv[i].cm, tv[i].f, tv[i].r);
        chk("tbl_sel", int'(sel_type), tv[i].sel);
        chk("tbl_motor", int'(motor_en), tv[i].mot);
        chk("tbl_chg", int'(mode_chg), tv[i].chg);
        if (tv[i].rdy >= 0) chk("tbl_ready", rdy_seen, tv[i].rdy);
      end
    // mode 1 -> key 2 -> key 3 two cycles later: mode 2 never shows
    step(4'b0100, 0, 0, 0, 0);
    chk("t2_motor_off", int'(motor_en), 0);
    for (int i = 0; i < 5; i++) begin
      step(i == 1 ? 4'b1000 : 4'b0000, 0, 0, 0, 0);
      chk("t2_sel_hold", int'(sel_type), 1);
    end
    step(0, 0, 0, 0, 0);
    chk("t2_sel3", int'(sel_type), 3);
    chk("t2_motor_on", int'(motor_en), 1);
    for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 0);
    chk("t4_before_to", int'(sel_type), 3);
    step(0, 0, 0, 0, 0);
    chk("t4_to_sel", int'(sel_type), 0);
    chk("t4_to_pulse", int'(rmt_timeout), 1);
    chk("t4_to_chg", int'(mode_chg), 1);
    step(0, 0, 0, 0, 0);
    chk("t4_to_once", int'(rmt_timeout), 0);
    step(0, 1, 3, 0, 0);
    for (int i = 0; i < DW; i++) step(0, 0, 0, 0, 0);
    tmo_hits = 0;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0);
      step(0, 1, 3, 0, 0);
    end
    chk("t4_no_timeout", tmo_hits, 0);
    chk("t4_still_rmt", int'(sel_type), 3);
    step(0, 1, 0, 0, 0);
    chk("t4_cmd_stop", int'(sel_type), 0);
    // key and cmd together in IDLE: key wins, cmd waits at the requester
    step(4'b0010, 1, 2, 0, 0);
    chk("t3_ready_low", rdy_seen, 0);
    for (int i = 0; i < DW; i++) step(0, 1, 2, 0, 0);
    chk("t3_sel1", int'(sel_type), 1);
    step(0, 1, 2, 0, 0);
    chk("t3_accept", rdy_seen, 1);
    chk("t3_dwell", int'(motor_en), 0);
    for (int i = 0; i < DW; i++) step(0, 0, 0, 0, 0);
    chk("t3_sel2", int'(sel_type), 2);
    chk("t3_motor", int'(motor_en), 1);
    step(4'b1000, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(4'b0001, 0, 0, 1, 0);
    chk("t5_fault_sel", int'(sel_type), 0);
    chk("t5_fault_chg", int'(mode_chg), 1);
    for (int i = 0; i < 4; i++) step(4'b0010, 1, 3, 1, 0);
    chk("t5_keys_ignored", int'(sel_type), 0);
    step(4'b0100, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t5_idle_ready", rdy_seen, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    chk("t5_sel_stays0", int'(sel_type), 0);
    step(4'b0100, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("t6_rst_sel", int'(sel_type), 0);
    chk("t6_rst_motor", int'(motor_en), 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
    chk("t6_no_apply", int'(sel_type), 0);
    chk("t6_no_motor", int'(motor_en), 0);
    fh = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] k;
      k = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      if (fh == 0 && $urandom_range(0, 59) == 0) fh = $urandom_range(1, 6);
      step(k, $urandom_range(0, 11) == 0, 2'($urandom_range(0, 3)), fh > 0,
           $urandom_range(0, 399) == 0);
      if (fh > 0) fh--;
    end
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
